// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep sequencer for the DDS_top/NCO datapath. One sweep config is
// latched on start. The FTW then walks from cfg_start to cfg_stop by cfg_step.
// Each FTW is held for cfg_dwell+1 cycles, and completion is flagged by a
// one-cycle done pulse. The block sits between the tt_um_dds pin interface and
// DDS_top.
//
// Optional feature macro: DDS_SWEEP_PINGPONG_EN
//   defined   : triangular (out-and-back) sweep. sweep_dir flips at cfg_stop.
//   undefined : sawtooth sweep. sweep_dir is constant for the whole run.
//
// Ports
//   clk          in   clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   start        in   sweep request pulse, honoured only in IDLE
//   abort        in   stop the sweep immediately (no done)
//   cfg_start    in   first FTW of sweep
//   cfg_stop     in   last FTW of sweep
//   cfg_step     in   FTW increment magnitude
//   cfg_dwell    in   cycles per FTW minus one
//   cfg_amp      in   amplitude during sweep
//   cfg_wavesel  in   wave select during sweep
//   cfg_loop     in   1 = repeat sweep until abort
//   ftw_out      out  FTW to NCO
//   amp_out      out  amplitude to DDS_top
//   wavesel_out  out  wave select to NCO
//   nco_en       out  NCO enable
//   busy         out  high while dwelling
//   sweep_dir    out  0 = FTW rising, 1 = falling
//   done         out  one-cycle pulse at normal sweep end
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
  parameter int FTW_W   = 6,
  parameter int AMP_W   = 6,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FTW_W-1:0]   cfg_start,
  input  logic [FTW_W-1:0]   cfg_stop,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [1:0]         cfg_wavesel,
  input  logic               cfg_loop,
  output logic [FTW_W-1:0]   ftw_out,
  output logic [AMP_W-1:0]   amp_out,
  output logic [1:0]         wavesel_out,
  output logic               nco_en,
  output logic               busy,
  output logic               sweep_dir,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, DWELL, FINISH} state_t;

  state_t             state_q;
  logic [FTW_W-1:0]   start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic               loop_q;

  logic [FTW_W-1:0]   ftw_q;
  logic [AMP_W-1:0]   amp_q;
  logic [1:0]         wavesel_q;
  logic               nco_en_q, busy_q, dir_q, done_q;

  // Values to apply when the dwell counter expires.
  logic [FTW_W-1:0]   ftw_d;
  logic               dir_d;
  logic               finish_d;

  // One step from cur towards tgt. The arithmetic is one bit wider so that
  // overshoot in either direction is detected and clamped, never wrapped.
  function automatic logic [FTW_W-1:0] step_toward(
    input logic [FTW_W-1:0] cur,
    input logic [FTW_W-1:0] step,
    input logic [FTW_W-1:0] tgt,
    input logic             down
  );
    logic [FTW_W:0] t;
    logic [FTW_W-1:0] r;
    if (!down) begin
      t = {1'b0, cur} + {1'b0, step};
      r = (t >= {1'b0, tgt}) ? tgt : t[FTW_W-1:0];
    end else begin
      t = {1'b0, cur} - {1'b0, step};
      // t[FTW_W] set means the subtraction went below zero.
      r = (t[FTW_W] || (t[FTW_W-1:0] <= tgt)) ? tgt : t[FTW_W-1:0];
    end
    return r;
  endfunction

`ifdef DDS_SWEEP_PINGPONG_EN
  // 0 = outbound leg (towards stop), 1 = return leg (towards start).
  logic leg_q, leg_d;

  always_comb begin
    ftw_d    = step_toward(ftw_q, step_q, leg_q ? start_q : stop_q, dir_q);
    dir_d    = dir_q;
    leg_d    = leg_q;
    finish_d = 1'b0;
    if (step_q == '0 || start_q == stop_q) begin
      // Degenerate sweep: there is no leg to reverse into.
      if (loop_q) ftw_d = start_q;
      else        finish_d = 1'b1;
    end else if (!leg_q && ftw_q == stop_q) begin
      // Turn around at stop; stop itself is not repeated.
      dir_d = ~dir_q;
      leg_d = 1'b1;
      ftw_d = step_toward(stop_q, step_q, start_q, ~dir_q);
    end else if (leg_q && ftw_q == start_q) begin
      if (loop_q) begin
        // New round trip; start is not repeated.
        dir_d = ~dir_q;
        leg_d = 1'b0;
        ftw_d = step_toward(start_q, step_q, stop_q, ~dir_q);
      end else begin
        finish_d = 1'b1;
      end
    end
  end
`else
  always_comb begin
    ftw_d    = step_toward(ftw_q, step_q, stop_q, dir_q);
    dir_d    = dir_q;
    finish_d = 1'b0;
    if (step_q == '0 || ftw_q == stop_q) begin
      if (loop_q) ftw_d = start_q;
      else        finish_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      loop_q    <= 1'b0;
      ftw_q     <= '0;
      amp_q     <= '0;
      wavesel_q <= '0;
      nco_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
      leg_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            start_q   <= cfg_start;
            stop_q    <= cfg_stop;
            step_q    <= cfg_step;
            dwell_q   <= cfg_dwell;
            loop_q    <= cfg_loop;
            cnt_q     <= cfg_dwell;
            ftw_q     <= cfg_start;
            amp_q     <= cfg_amp;
            wavesel_q <= cfg_wavesel;
            nco_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            dir_q     <= (cfg_stop < cfg_start);
`ifdef DDS_SWEEP_PINGPONG_EN
            leg_q     <= 1'b0;
`endif
            state_q   <= DWELL;
          end
        end
        DWELL: begin
          if (abort) begin
            nco_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            amp_q     <= '0;
            wavesel_q <= '0;
            state_q   <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else if (finish_d) begin
            done_q    <= 1'b1;
            nco_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            amp_q     <= '0;
            wavesel_q <= '0;
            state_q   <= FINISH;
          end else begin
            // Step (or loop restart) in the same cycle the counter expires.
            ftw_q <= ftw_d;
            dir_q <= dir_d;
            cnt_q <= dwell_q;
`ifdef DDS_SWEEP_PINGPONG_EN
            leg_q <= leg_d;
`endif
          end
        end
        FINISH: begin
          // Outputs are already quiet; abort here lands in the same place.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ftw_out     = ftw_q;
  assign amp_out     = amp_q;
  assign wavesel_out = wavesel_q;
  assign nco_en      = nco_en_q;
  assign busy        = busy_q;
  assign sweep_dir   = dir_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Self-checking bench for dds_sweep_ctrl. For each sweep, the expected FTW
// sequence is built as a list from the sweep rules, using plain integer
// arithmetic. Every cycle is then compared against that list. Config inputs
// and start are scrambled while a sweep runs, and the output must not react.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;
  localparam int FTW_W   = 6;
  localparam int AMP_W   = 6;
  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [FTW_W-1:0]   cfg_start;
  logic [FTW_W-1:0]   cfg_stop;
  logic [FTW_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [AMP_W-1:0]   cfg_amp;
  logic [1:0]         cfg_wavesel;
  logic               cfg_loop;
  logic [FTW_W-1:0]   ftw_out;
  logic [AMP_W-1:0]   amp_out;
  logic [1:0]         wavesel_out;
  logic               nco_en;
  logic               busy;
  logic               sweep_dir;
  logic               done;

  dds_sweep_ctrl #(.FTW_W(FTW_W), .AMP_W(AMP_W), .DWELL_W(DWELL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_step    (cfg_step),
    .cfg_dwell   (cfg_dwell),
    .cfg_amp     (cfg_amp),
    .cfg_wavesel (cfg_wavesel),
    .cfg_loop    (cfg_loop),
    .ftw_out     (ftw_out),
    .amp_out     (amp_out),
    .wavesel_out (wavesel_out),
    .nco_en      (nco_en),
    .busy        (busy),
    .sweep_dir   (sweep_dir),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input int ftw, input int dir, input int bsy, input int en,
                            input int amp, input int wav, input int dn);
    check_eq("ftw_out", 32'(ftw_out), ftw);
    check_eq("sweep_dir", 32'(sweep_dir), dir);
    check_eq("busy", 32'(busy), bsy);
    check_eq("nco_en", 32'(nco_en), en);
    check_eq("amp_out", 32'(amp_out), amp);
    check_eq("wavesel_out", 32'(wavesel_out), wav);
    check_eq("done", 32'(done), dn);
  endtask

  // Reference sweep model: the ordered list of FTW values (with direction),
  // and the index that a looping sweep wraps back to.
  int exp_ftw[$];
  int exp_dir[$];
  int wrap_idx;

  function automatic int toward(input int v, input int step, input int tgt);
    if (tgt >= v) return (v + step > tgt) ? tgt : v + step;
    else          return (v - step < tgt) ? tgt : v - step;
  endfunction

  task automatic build_list(input int s, input int e, input int st);
    int v;
    int d0;
    exp_ftw.delete();
    exp_dir.delete();
    wrap_idx = 0;
    d0 = (e < s) ? 1 : 0;
    v = s;
    forever begin
      exp_ftw.push_back(v);
      exp_dir.push_back(d0);
      if (v == e || st == 0) break;
      v = toward(v, st, e);
    end
`ifdef DDS_SWEEP_PINGPONG_EN
    if (st != 0 && s != e) begin
      v = e;
      do begin
        v = toward(v, st, s);
        exp_ftw.push_back(v);
        exp_dir.push_back(1 - d0);
      end while (v != s);
      // Later round trips resume one step past start.
      wrap_idx = 1;
    end
`endif
  endtask

  // Run one sweep. Entered just after a falling edge. For looping sweeps,
  // abort is raised after run_cycles cycles.
  task automatic run_sweep(input int s, input int e, input int st, input int dw,
                           input int amp, input int wav, input int lp, input int run_cycles);
    int n, k, idx, sz;
    build_list(s, e, st);
    sz = exp_ftw.size();
    n  = lp ? run_cycles : sz * (dw + 1);
    $display("sweep start=%0d stop=%0d step=%0d dwell=%0d loop=%0d len=%0d", s, e, st, dw, lp, sz);
    cfg_start   = FTW_W'(s);
    cfg_stop    = FTW_W'(e);
    cfg_step    = FTW_W'(st);
    cfg_dwell   = DWELL_W'(dw);
    cfg_amp     = AMP_W'(amp);
    cfg_wavesel = 2'(wav);
    cfg_loop    = lp[0];
    start = 1'b1;
    abort = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      k = c / (dw + 1);
      idx = (k < sz) ? k : wrap_idx + (k - wrap_idx) % (sz - wrap_idx);
      check_outs(exp_ftw[idx], exp_dir[idx], 1, 1, amp, wav, 0);
      // Config changes and repeat starts during the sweep must be ignored.
      cfg_start   = FTW_W'($urandom);
      cfg_stop    = FTW_W'($urandom);
      cfg_step    = FTW_W'($urandom);
      cfg_dwell   = DWELL_W'($urandom);
      cfg_amp     = AMP_W'($urandom);
      cfg_wavesel = 2'($urandom);
      cfg_loop    = 1'($urandom);
      start       = ($urandom_range(0, 3) == 0);
    end
    if (!lp) begin
      @(negedge clk);
      check_outs(exp_ftw[sz-1], exp_dir[sz-1], 0, 0, 0, 0, 1);
      start = 1'b0;
      @(negedge clk);
      check_eq("done_after", 32'(done), 0);
      check_eq("busy_after", 32'(busy), 0);
    end else begin
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      check_eq("abort_nco_en", 32'(nco_en), 0);
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_amp", 32'(amp_out), 0);
      check_eq("abort_wavesel", 32'(wavesel_out), 0);
      check_eq("abort_done", 32'(done), 0);
      abort = 1'b0;
      @(negedge clk);
      check_eq("abort_done2", 32'(done), 0);
      check_eq("abort_busy2", 32'(busy), 0);
    end
  endtask

  initial begin
    int s, e, st;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
    cfg_amp = '0; cfg_wavesel = '0; cfg_loop = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outs(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sweeps.
    run_sweep(5, 20, 5, 2, 33, 2, 0, 0);
    run_sweep(30, 3, 10, 0, 17, 3, 0, 0);
    run_sweep(60, 63, 2, 0, 63, 1, 1, 14);
    run_sweep(9, 9, 3, 1, 5, 1, 0, 0);
    run_sweep(12, 40, 0, 1, 7, 2, 0, 0);
`ifdef DDS_SWEEP_PINGPONG_EN
    run_sweep(0, 8, 4, 1, 21, 3, 0, 0);
    run_sweep(10, 2, 3, 0, 11, 2, 1, 25);
`endif

    // start together with abort in IDLE must not start a sweep.
    start = 1'b1; abort = 1'b1;
    cfg_start = 6'd7; cfg_stop = 6'd9; cfg_step = 6'd1; cfg_amp = 6'd4; cfg_wavesel = 2'd1;
    @(negedge clk);
    check_eq("startabort_busy", 32'(busy), 0);
    check_eq("startabort_nco_en", 32'(nco_en), 0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("startabort_busy2", 32'(busy), 0);

    // Asynchronous reset in the middle of a falling sweep.
    cfg_start = 6'd30; cfg_stop = 6'd3; cfg_step = 6'd4; cfg_dwell = 8'd3;
    cfg_amp = 6'd45; cfg_wavesel = 2'd3; cfg_loop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("prereset_busy", 32'(busy), 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("postreset_busy", 32'(busy), 0);
    check_eq("postreset_done", 32'(done), 0);

    // Randomized sweeps.
    for (int r = 0; r < 30; r++) begin
      s  = int'($urandom_range(0, 63));
      e  = int'($urandom_range(0, 63));
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : int'($urandom_range(0, 63));
      run_sweep(s, e, st, int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                int'($urandom_range(1, 40)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
